// File: rtl/game_pkg.sv
// Shared game definitions: state codes, field widths and default game constants
// used by the collision controller and by the HUD / score overlay.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_HIT       = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

    localparam int SCORE_W = 14;
    localparam int LIVES_W = 2;
    localparam int DIV_W   = 3;   // frame divider feeding the score
    localparam int INV_W   = 6;   // invulnerability frame counter

    localparam int DEF_LIVES         = 3;
    localparam int DEF_INVULN_FRAMES = 60;
    localparam int DEF_SCORE_DIV     = 6;
    localparam int DEF_SCORE_MAX     = 9999;

    // Score increment that sticks at the ceiling instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                   input logic [SCORE_W-1:0] max_value);
        return (value >= max_value) ? max_value : value + {{(SCORE_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: remembers the previous level and emits a registered
// one-cycle pulse when the level goes from 0 to 1.
module rise_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic level_q_reg;
    logic rise_reg;

    // Track the previous level and register the AND-NOT edge term.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_q_reg <= 1'b0;
            rise_reg    <= 1'b0;
        end else begin
            level_q_reg <= i_level;
            rise_reg    <= i_level & ~level_q_reg;
        end
    end

    assign o_rise = rise_reg;

endmodule

// File: rtl/obstacle_collision_ctrl.sv
// Per-frame collision and game-state controller. Accumulates player/obstacle
// overlap during the pixel scan and, on each frame tick, applies damage, runs
// the invulnerability window, advances the score and sequences the game.
module obstacle_collision_ctrl
    import game_pkg::*;
#(
    parameter int N_OBS         = 2,
    parameter int LIVES         = DEF_LIVES,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int SCORE_DIV     = DEF_SCORE_DIV,
    parameter int SCORE_MAX     = DEF_SCORE_MAX
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_v_sync,
    input  logic               i_start,
    input  logic               i_player_hit,
    input  logic [N_OBS-1:0]   i_obstacle_hit,
    output logic [1:0]         o_state,
    output logic [LIVES_W-1:0] o_lives,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_hit_pulse,
    output logic               o_invuln,
    output logic               o_game_over
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INVULN_FRAMES - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCORE_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_TOP  = SCORE_W'(SCORE_MAX);

    // Bit 0: vertical sync (frame tick), bit 1: start button.
    logic [1:0] edge_in;
    logic [1:0] edge_rise;
    logic       tick;
    logic       start_rise;
    logic       ov;

    assign edge_in = {i_start, i_v_sync};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rise
            rise_detect u_rise (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_level (edge_in[gi]),
                .o_rise  (edge_rise[gi])
            );
        end
    endgenerate

    assign tick       = edge_rise[0];
    assign start_rise = edge_rise[1];
    assign ov         = i_player_hit & (|i_obstacle_hit);

    game_state_t        state_reg, state_next;
    logic [LIVES_W-1:0] lives_reg, lives_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [INV_W-1:0]   inv_cnt_reg, inv_cnt_next;
    logic               collide_reg, collide_next;
    logic               hit_pulse_reg, hit_pulse_next;
    logic               invuln_reg, invuln_next;
    logic               game_over_reg, game_over_next;

    // Game state, counters and registered status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            lives_reg     <= LIVES_INIT;
            score_reg     <= '0;
            div_reg       <= '0;
            inv_cnt_reg   <= '0;
            collide_reg   <= 1'b0;
            hit_pulse_reg <= 1'b0;
            invuln_reg    <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lives_reg     <= lives_next;
            score_reg     <= score_next;
            div_reg       <= div_next;
            inv_cnt_reg   <= inv_cnt_next;
            collide_reg   <= collide_next;
            hit_pulse_reg <= hit_pulse_next;
            invuln_reg    <= invuln_next;
            game_over_reg <= game_over_next;
        end
    end

    // Next-state logic: start handling, damage, invulnerability and scoring.
    always_comb begin
        state_next     = state_reg;
        lives_next     = lives_reg;
        score_next     = score_reg;
        div_next       = div_reg;
        inv_cnt_next   = inv_cnt_reg;
        hit_pulse_next = 1'b0;
        // The tick closes the frame: the old flag is judged, and an overlap
        // on the tick cycle itself opens the next frame's flag.
        collide_next   = tick ? ov : (collide_reg | ov);

        // Score divider runs on every tick while a game is in progress.
        if (tick && (state_reg == ST_PLAYING || state_reg == ST_HIT)) begin
            if (div_reg == DIV_LAST) begin
                div_next   = '0;
                score_next = sat_inc(score_reg, SCORE_TOP);
            end else begin
                div_next = div_reg + 1'b1;
            end
        end

        case (state_reg)
            ST_IDLE, ST_GAME_OVER: begin
                // Start wins over a coincident tick: no score/damage update.
                if (start_rise) begin
                    state_next   = ST_PLAYING;
                    lives_next   = LIVES_INIT;
                    score_next   = '0;
                    div_next     = '0;
                    inv_cnt_next = '0;
                    collide_next = 1'b0;
                end
            end
            ST_PLAYING: begin
                if (tick && collide_reg) begin
                    lives_next     = lives_reg - 1'b1;
                    hit_pulse_next = 1'b1;
                    if (lives_reg == {{(LIVES_W-1){1'b0}}, 1'b1}) begin
                        state_next = ST_GAME_OVER;
                    end else begin
                        state_next   = ST_HIT;
                        inv_cnt_next = INV_LOAD;
                    end
                end
            end
            ST_HIT: begin
                if (tick) begin
                    if (inv_cnt_reg == '0) begin
                        state_next = ST_PLAYING;
                    end else begin
                        inv_cnt_next = inv_cnt_reg - 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        invuln_next    = (state_next == ST_HIT);
        game_over_next = (state_next == ST_GAME_OVER);
    end

    assign o_state     = state_reg;
    assign o_lives     = lives_reg;
    assign o_score     = score_reg;
    assign o_hit_pulse = hit_pulse_reg;
    assign o_invuln    = invuln_reg;
    assign o_game_over = game_over_reg;

endmodule

// File: tb/tb_obstacle_collision_ctrl.sv
// Directed bench for obstacle_collision_ctrl: start, damage, invulnerability
// window, game over, restart, scoring, saturation and asynchronous reset.
module tb_obstacle_collision_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v_sync = 1'b0;
    logic        start = 1'b0;
    logic        player_hit = 1'b0;
    logic [1:0]  obs_hit = 2'b00;
    logic [1:0]  state;
    logic [1:0]  lives;
    logic [13:0] score;
    logic        hit_pulse;
    logic        invuln;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obstacle_collision_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_v_sync       (v_sync),
        .i_start        (start),
        .i_player_hit   (player_hit),
        .i_obstacle_hit (obs_hit),
        .o_state        (state),
        .o_lives        (lives),
        .o_score        (score),
        .o_hit_pulse    (hit_pulse),
        .o_invuln       (invuln),
        .o_game_over    (game_over)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int lv, input int sc,
                             input int hp, input int inv, input int go);
        check({tag, ".state"},     32'(state),     32'(st));
        check({tag, ".lives"},     32'(lives),     32'(lv));
        check({tag, ".score"},     32'(score),     32'(sc));
        check({tag, ".hit_pulse"}, 32'(hit_pulse), 32'(hp));
        check({tag, ".invuln"},    32'(invuln),    32'(inv));
        check({tag, ".game_over"}, 32'(game_over), 32'(go));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One v_sync rise; on return the tick's update is visible.
    task automatic frame();
        v_sync = 1'b1;
        step(1);
        v_sync = 1'b0;
        step(1);
    endtask

    // v_sync rise with the overlap present only on the tick cycle.
    task automatic frame_ov_on_tick();
        v_sync = 1'b1;
        step(1);
        v_sync = 1'b0;
        player_hit = 1'b1;
        obs_hit = 2'b01;
        step(1);
        player_hit = 1'b0;
        obs_hit = 2'b00;
    endtask

    // A single overlapping pixel in the middle of a frame.
    task automatic pixel_hit(input logic [1:0] obs);
        player_hit = 1'b1;
        obs_hit = obs;
        step(1);
        player_hit = 1'b0;
        obs_hit = 2'b00;
        step(1);
    endtask

    initial begin
        step(3);
        check_all("reset", 0, 3, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(2);

        // Start: PLAYING two cycles after the press.
        start = 1'b1;
        step(1);
        check("start_latency1.state", 32'(state), 32'd0);
        step(1);
        check_all("start", 1, 3, 0, 0, 0, 0);
        start = 1'b0;

        // First hit (tick 1).
        pixel_hit(2'b10);
        frame();
        check_all("hit1", 2, 2, 0, 1, 1, 0);
        step(1);
        check("hit1_pulse_clear", 32'(hit_pulse), 32'd0);

        // Overlap every frame during the window; 60th window tick returns to PLAYING.
        for (int j = 1; j <= 60; j++) begin
            pixel_hit(2'b01);
            frame();
            if (j < 60) begin
                check($sformatf("window%0d.invuln", j), 32'(invuln), 32'd1);
                check($sformatf("window%0d.lives", j), 32'(lives), 32'd2);
            end
        end
        check_all("window_end", 1, 2, 10, 0, 0, 0);   // 61 ticks

        // First overlap after the window costs a life (tick 62).
        pixel_hit(2'b11);
        frame();
        check_all("hit2", 2, 1, 10, 1, 1, 0);
        repeat (60) frame();
        check_all("hit2_end", 1, 1, 20, 0, 0, 0);     // 122 ticks

        // Third hit ends the game (tick 123).
        pixel_hit(2'b10);
        frame();
        check_all("hit3", 3, 0, 20, 1, 0, 1);
        repeat (12) begin
            pixel_hit(2'b10);
            frame();
        end
        check_all("game_over_frozen", 3, 0, 20, 0, 0, 1);

        // Restart coinciding with a tick: start wins, tick ignored.
        pixel_hit(2'b10);
        start = 1'b1;
        v_sync = 1'b1;
        step(1);
        v_sync = 1'b0;
        step(1);
        start = 1'b0;
        check_all("restart_with_tick", 1, 3, 0, 0, 0, 0);
        repeat (5) frame();
        check("score_after5", 32'(score), 32'd0);
        frame();
        check("score_after6", 32'(score), 32'd1);
        repeat (54) frame();
        check_all("score_60", 1, 3, 10, 0, 0, 0);

        // Overlap only on the tick cycle counts toward the next frame.
        frame_ov_on_tick();
        check_all("ov_on_tick", 1, 3, 10, 0, 0, 0);   // 61 ticks
        frame();
        check_all("ov_next_tick", 2, 2, 10, 1, 1, 0); // 62 ticks, divider at 2

        // Preload 9998 with divider at 2: 4th tick gives 9999, then it saturates.
        force dut.score_reg = 14'd9998;
        #1;
        release dut.score_reg;
        check("preload", 32'(score), 32'd9998);
        repeat (3) frame();
        check("score_pre_wrap", 32'(score), 32'd9998);
        repeat (9) frame();
        check("score_saturated", 32'(score), 32'd9999);

        // Asynchronous reset mid-frame, observed before any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 3, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        start = 1'b1;
        step(2);
        start = 1'b0;
        check_all("start_after_reset", 1, 3, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/obstacle_collision_ctrl.md
# obstacle_collision_ctrl

Per-frame collision and game-state controller directly downstream of the obstacle sprite generators and the player sprite. It samples the per-pixel `o_sprite_hit` flags while the pixel scan runs and accumulates any overlap across the frame. At each vertical-sync edge it applies damage, runs the invulnerability window, advances the score and sequences IDLE → PLAYING → GAME_OVER. Its outputs drive the HUD/score overlay and the restart logic.

## Interface
- `N_OBS`, 2: number of obstacle sprite hit inputs.
- `LIVES`, 3: lives loaded on reset and on start.
- `INVULN_FRAMES`, 60: frames of invulnerability after a hit.
- `SCORE_DIV`, 6: PLAYING frames per score point.
- `SCORE_MAX`, 9999: score saturation value.
- `i_clk`  in  1  pixel clock; single clock domain.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_v_sync`  in  1  vertical sync, synchronous to `i_clk`; a rising edge marks the frame boundary.
- `i_start`  in  1  start/restart button level, already debounced and synchronous.
- `i_player_hit`  in  1  player sprite opaque at the current pixel.
- `i_obstacle_hit`  in  N_OBS  per-obstacle `o_sprite_hit` at the current pixel.
- `o_state`  out  2  game state code.
- `o_lives`  out  2  remaining lives.
- `o_score`  out  14  binary score, 0..SCORE_MAX.
- `o_hit_pulse`  out  1  one-cycle pulse when a life is lost.
- `o_invuln`  out  1  high while the invulnerability window runs; the HUD uses it to blink the player.
- `o_game_over`  out  1  high in GAME_OVER.

## Operation
- Frame tick: `tick` = `i_v_sync` & ~`vs_q`, where `vs_q` is `i_v_sync` registered. `tick` is high for exactly one cycle per rising edge.
- Start edge: `start_rise` = `i_start` & ~`st_q`, where `st_q` is `i_start` registered.
- Overlap: `ov` = `i_player_hit` & |`i_obstacle_hit`.
- `frame_collide` sets on any cycle with `ov` = 1. On a `tick` cycle the old value is evaluated and the register loads `ov`, so an overlap on the tick cycle counts toward the next frame.
- States:
  - IDLE = 0.
  - PLAYING = 1.
  - HIT = 2 (invulnerable).
  - GAME_OVER = 3.
- Reset values:
  - state IDLE.
  - `o_lives` = LIVES.
  - `o_score` = 0.
  - `frame_collide`, `o_hit_pulse`, `o_invuln`, `o_game_over` = 0.
  - frame and invulnerability counters = 0.
  - `vs_q`, `st_q` = 0.
- IDLE or GAME_OVER with `start_rise` → PLAYING. Same edge: lives = LIVES, score = 0, counters = 0, `frame_collide` = 0. `start_rise` is ignored in PLAYING and HIT.
- PLAYING, on `tick` with `frame_collide` = 1:
  - lives − 1, `o_hit_pulse` = 1 for one cycle.
  - If the new lives = 0 → GAME_OVER; otherwise → HIT with the invulnerability counter = INVULN_FRAMES − 1.
- HIT, on `tick`: collisions are ignored. Counter − 1; when the counter is 0 on the tick → PLAYING.
- Score: in PLAYING and HIT, every `tick` increments the frame divider. When the divider reaches SCORE_DIV − 1 it wraps to 0 and score + 1, saturating at SCORE_MAX. The score freezes in IDLE and GAME_OVER.
- Simultaneous `tick` and `start_rise` in GAME_OVER or IDLE: start wins, and the tick causes no score or damage update.
- `o_invuln` = (state == HIT). `o_game_over` = (state == GAME_OVER).
- Asynchronous reset mid-frame clears the state immediately. The first tick after release is the edge of the first `i_v_sync` rise sampled after release.

## Timing
- `i_v_sync` rise at clock k → `tick` at k+1 → state, lives, score and `o_hit_pulse` valid at k+2.
- `i_start` rise at clock k → PLAYING visible at k+2.
- `ov` at cycle k is registered into `frame_collide` at k+1. The last pixel of a frame counts if it precedes the tick cycle.
- All outputs are registered; there are no combinational paths from input to output.
- The frame divider is 3 bits wide; the invulnerability counter is 6 bits wide.

## Structure
- Shared package `game_pkg`:
  - state enum `game_state_t` (IDLE/PLAYING/HIT/GAME_OVER).
  - `SCORE_W` = 14, `LIVES_W` = 2.
  - defaults for LIVES, INVULN_FRAMES and SCORE_MAX, so the HUD and score overlay share them.
- Sub-module `rise_detect`: register plus AND-NOT, async active-low reset. Instantiated twice, for `i_v_sync` and `i_start`.
- All remaining logic stays in one FSM with its counters.

## Test plan
- Reset release, then `i_start` pulse → state 1 two cycles later, lives 3, score 0, all other outputs 0.
- One-pixel `i_player_hit` & `i_obstacle_hit`=2'b10 in frame n → one `o_hit_pulse` at the next tick+1, lives 2, state 2, `o_invuln` = 1 for exactly 60 ticks, then state 1.
- Overlap every frame while in HIT → lives stay 2. The first overlap after returning to PLAYING → lives 1.
- Three hits spaced beyond the invulnerability window → lives 0, state 3, `o_game_over` = 1, score frozen. `i_start` → lives 3, score 0, state 1.
- 60 PLAYING ticks with no overlap → score 10. Preload the score to 9998 and run 12 ticks → score 9999, saturated.
- Overlap asserted only on the tick cycle → no damage on that tick; damage on the following tick. Assert `i_rst_n` low mid-frame → outputs at reset values asynchronously.
